// File: rtl/adc_pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock, retries on timeout and
// holds the ADC path in reset until lock has been stable; counts loss-of-lock in RUN.
module adc_pll_lock_supervisor #(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int MAX_RETRIES      = 7,
   parameter int CNT_W            = 17
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       force_relock,
   input  logic       clear_status,
   output logic       pll_rst,
   output logic       adc_rst_n,
   output logic       ready,
   output logic       fail,
   output logic       lock_lost,
   output logic [7:0] lock_loss_cnt,
   output logic [3:0] retry_cnt
);

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABILIZE,
      ST_RUN,
      ST_FAIL
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       retry_nx;
   logic             lost_nx;
   logic [7:0]       loss_cnt_nx;
   logic             loss_event;
   logic             sync_q1, locked_s;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1  <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync_q1  <= pll_locked;
         locked_s <= sync_q1;
      end
   end

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      retry_nx   = retry_cnt;
      loss_event = 1'b0;

      if (force_relock) begin
         state_nx = ST_PLL_RST;
         cnt_nx   = '0;
         retry_nx = '0;
      end else begin
         unique case (state)
            ST_PLL_RST: begin
               if (cnt == RST_LAST) begin
                  state_nx = ST_WAIT_LOCK;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_nx = ST_STABILIZE;
                  cnt_nx   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt_nx = '0;
                  if (retry_cnt == RETRY_MAX) begin
                     state_nx = ST_FAIL;
                  end else begin
                     state_nx = ST_PLL_RST;
                     retry_nx = retry_cnt + 4'd1;
                  end
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            ST_STABILIZE: begin
               // Any dropout restarts the acquisition wait without spending a retry.
               if (!locked_s) begin
                  state_nx = ST_WAIT_LOCK;
                  cnt_nx   = '0;
               end else if (cnt == STABLE_LAST) begin
                  state_nx = ST_RUN;
                  cnt_nx   = '0;
                  retry_nx = '0;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_nx   = ST_PLL_RST;
                  cnt_nx     = '0;
                  loss_event = 1'b1;
               end
            end
            ST_FAIL: begin
               state_nx = ST_FAIL;
            end
            default: begin
               state_nx = ST_PLL_RST;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   // A loss in the same cycle as clear_status wins, leaving a fresh count of one.
   always_comb begin
      lost_nx     = lock_lost;
      loss_cnt_nx = lock_loss_cnt;
      if (clear_status) begin
         lost_nx     = 1'b0;
         loss_cnt_nx = '0;
      end
      if (loss_event) begin
         lost_nx = 1'b1;
         if (clear_status)
            loss_cnt_nx = 8'd1;
         else if (lock_loss_cnt != 8'hFF)
            loss_cnt_nx = lock_loss_cnt + 8'd1;
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_PLL_RST;
         cnt           <= '0;
         retry_cnt     <= '0;
         lock_lost     <= 1'b0;
         lock_loss_cnt <= '0;
         pll_rst       <= 1'b1;
         adc_rst_n     <= 1'b0;
         ready         <= 1'b0;
         fail          <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         retry_cnt     <= retry_nx;
         lock_lost     <= lost_nx;
         lock_loss_cnt <= loss_cnt_nx;
         // Outputs decode the next state so they switch on the transition edge.
         pll_rst       <= (state_nx == ST_PLL_RST) || (state_nx == ST_FAIL);
         adc_rst_n     <= (state_nx == ST_RUN);
         ready         <= (state_nx == ST_RUN);
         fail          <= (state_nx == ST_FAIL);
      end
   end

endmodule

// File: tb/tb_adc_pll_lock_supervisor.sv
// Directed bench for adc_pll_lock_supervisor with short timing parameters;
// inputs driven and outputs sampled on the falling edge of refclk.
module tb_adc_pll_lock_supervisor;

   localparam int RST_PULSE = 4;
   localparam int STABLE    = 8;
   localparam int TIMEOUT   = 32;
   localparam int MAXR      = 2;

   localparam logic [16:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};

   logic       refclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       force_relock = 1'b0;
   logic       clear_status = 1'b0;
   logic       pll_rst, adc_rst_n, ready, fail, lock_lost;
   logic [7:0] lock_loss_cnt;
   logic [3:0] retry_cnt;

   int checks = 0;
   int failures = 0;

   adc_pll_lock_supervisor #(
      .RST_PULSE_CYC   (RST_PULSE),
      .LOCK_STABLE_CYC (STABLE),
      .LOCK_TIMEOUT_CYC(TIMEOUT),
      .MAX_RETRIES     (MAXR),
      .CNT_W           (17)
   ) dut (
      .refclk       (refclk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .force_relock (force_relock),
      .clear_status (clear_status),
      .pll_rst      (pll_rst),
      .adc_rst_n    (adc_rst_n),
      .ready        (ready),
      .fail         (fail),
      .lock_lost    (lock_lost),
      .lock_loss_cnt(lock_loss_cnt),
      .retry_cnt    (retry_cnt)
   );

   always #5 refclk = ~refclk;

   function automatic logic [16:0] out_vec();
      return {pll_rst, adc_rst_n, ready, fail, lock_lost, lock_loss_cnt, retry_cnt};
   endfunction

   task automatic tick();
      @(posedge refclk);
      @(negedge refclk);
   endtask

   task automatic do_reset();
      pll_locked   = 1'b0;
      force_relock = 1'b0;
      clear_status = 1'b0;
      rst_n        = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   // Edges until pll_rst leaves the given level (bounded).
   task automatic edges_while_pll_rst(input logic level, input int bound, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (pll_rst === level && n < bound);
   endtask

   // Edges until ready reaches the given level (bounded).
   task automatic edges_until_ready(input logic level, input int bound, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (ready !== level && n < bound);
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      pll_locked = 1'b0;
      repeat (2) tick();
      checks++;
      if (out_vec() !== RESET_VEC) begin
         failures++;
         $display("FAIL reset_values: got %h expected %h", out_vec(), RESET_VEC);
      end
      rst_n = 1'b1;
      edges_while_pll_rst(1'b1, 100, n);
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL first_pulse_len: got %0d expected 4", n);
      end
      repeat (10) tick();
      pll_locked = 1'b1;
      edges_until_ready(1'b1, 50, n);
      checks++;
      if (n !== 11) begin
         failures++;
         $display("FAIL lock_to_ready_latency: got %0d expected 11", n);
      end
      checks++;
      if ({adc_rst_n, pll_rst, fail, retry_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL run_outputs: got adc=%b pll_rst=%b fail=%b retry=%0d expected 1 0 0 0",
                  adc_rst_n, pll_rst, fail, retry_cnt);
      end
   endtask

   task automatic test_timeout_retry();
      int n;
      int bad;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         edges_while_pll_rst(1'b1, 100, n);
         checks++;
         if (n !== 4) begin
            failures++;
            $display("FAIL retry_pulse_len[%0d]: got %0d expected 4", k, n);
         end
         edges_while_pll_rst(1'b0, 100, n);
         checks++;
         if (n !== 32) begin
            failures++;
            $display("FAIL wait_timeout_len[%0d]: got %0d expected 32", k, n);
         end
         checks++;
         if ({fail, retry_cnt} !== {(k == 2), 4'((k == 2) ? 2 : k + 1)}) begin
            failures++;
            $display("FAIL retry_state[%0d]: got fail=%b retry=%0d expected fail=%b retry=%0d",
                     k, fail, retry_cnt, (k == 2), (k == 2) ? 2 : k + 1);
         end
      end
      bad = 0;
      repeat (40) begin
         tick();
         if (pll_rst !== 1'b1 || fail !== 1'b1 || ready !== 1'b0 || retry_cnt !== 4'd2) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL fail_hold: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_force_relock();
      int n;
      pll_locked = 1'b1;
      repeat (3) tick();
      checks++;
      if (fail !== 1'b1) begin
         failures++;
         $display("FAIL fail_ignores_lock: got %b expected 1", fail);
      end
      force_relock = 1'b1;
      tick();
      force_relock = 1'b0;
      checks++;
      if ({fail, pll_rst, retry_cnt} !== {1'b0, 1'b1, 4'd0}) begin
         failures++;
         $display("FAIL relock_exit: got fail=%b pll_rst=%b retry=%0d expected 0 1 0",
                  fail, pll_rst, retry_cnt);
      end
      edges_while_pll_rst(1'b1, 100, n);
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL relock_pulse_len: got %0d edges after relock edge expected 4", n);
      end
      edges_until_ready(1'b1, 50, n);
      checks++;
      if (n !== 9 || retry_cnt !== 4'd0) begin
         failures++;
         $display("FAIL relock_ready: got %0d edges retry=%0d expected 9 edges retry=0", n, retry_cnt);
      end
   endtask

   task automatic test_stabilize_drop();
      int n;
      do_reset();
      edges_while_pll_rst(1'b1, 100, n);
      pll_locked = 1'b1;
      repeat (8) tick();
      pll_locked = 1'b0;
      repeat (3) tick();
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL stab_drop_no_ready: got %b expected 0", ready);
      end
      pll_locked = 1'b1;
      edges_until_ready(1'b1, 60, n);
      checks++;
      if (n !== 11) begin
         failures++;
         $display("FAIL stab_restart_latency: got %0d expected 11", n);
      end
      checks++;
      if ({lock_lost, lock_loss_cnt} !== {1'b0, 8'd0}) begin
         failures++;
         $display("FAIL stab_no_loss: got lost=%b cnt=%0d expected 0 0", lock_lost, lock_loss_cnt);
      end
   endtask

   task automatic test_run_loss();
      int n;
      int exp_cnt;
      for (int i = 1; i <= 300; i++) begin
         exp_cnt = (i > 255) ? 255 : i;
         pll_locked = 1'b0;
         edges_until_ready(1'b0, 20, n);
         checks++;
         if (n !== 3) begin
            failures++;
            $display("FAIL loss_latency[%0d]: got %0d expected 3", i, n);
         end
         checks++;
         if ({adc_rst_n, pll_rst, lock_lost, lock_loss_cnt} !== {1'b0, 1'b1, 1'b1, 8'(exp_cnt)}) begin
            failures++;
            $display("FAIL loss_state[%0d]: got adc=%b pll_rst=%b lost=%b cnt=%0d expected 0 1 1 %0d",
                     i, adc_rst_n, pll_rst, lock_lost, lock_loss_cnt, exp_cnt);
         end
         pll_locked = 1'b1;
         edges_until_ready(1'b1, 60, n);
         checks++;
         if (n !== 13) begin
            failures++;
            $display("FAIL loss_reacquire[%0d]: got %0d expected 13", i, n);
         end
      end
   endtask

   task automatic test_clear_status();
      int n;
      do_reset();
      edges_while_pll_rst(1'b1, 100, n);
      pll_locked = 1'b1;
      edges_until_ready(1'b1, 60, n);
      repeat (5) begin
         pll_locked = 1'b0;
         edges_until_ready(1'b0, 20, n);
         pll_locked = 1'b1;
         edges_until_ready(1'b1, 60, n);
      end
      checks++;
      if (lock_loss_cnt !== 8'd5) begin
         failures++;
         $display("FAIL clear_setup_cnt: got %0d expected 5", lock_loss_cnt);
      end
      pll_locked = 1'b0;
      repeat (2) tick();
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      checks++;
      if ({ready, lock_lost, lock_loss_cnt} !== {1'b0, 1'b1, 8'd1}) begin
         failures++;
         $display("FAIL clear_vs_loss: got ready=%b lost=%b cnt=%0d expected 0 1 1",
                  ready, lock_lost, lock_loss_cnt);
      end
      pll_locked = 1'b1;
      edges_until_ready(1'b1, 60, n);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      checks++;
      if ({ready, lock_lost, lock_loss_cnt} !== {1'b1, 1'b0, 8'd0}) begin
         failures++;
         $display("FAIL clear_alone: got ready=%b lost=%b cnt=%0d expected 1 0 0",
                  ready, lock_lost, lock_loss_cnt);
      end
   endtask

   task automatic test_async_reset();
      int n;
      pll_locked = 1'b0;
      edges_until_ready(1'b0, 20, n);
      pll_locked = 1'b1;
      edges_while_pll_rst(1'b1, 100, n);
      repeat (4) tick();
      checks++;
      if ({pll_rst, ready, lock_lost, lock_loss_cnt} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
         failures++;
         $display("FAIL pre_async_state: got pll_rst=%b ready=%b lost=%b cnt=%0d expected 0 0 1 1",
                  pll_rst, ready, lock_lost, lock_loss_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_vec() !== RESET_VEC) begin
         failures++;
         $display("FAIL async_reset_values: got %h expected %h", out_vec(), RESET_VEC);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_timeout_retry();
      test_force_relock();
      test_stabilize_drop();
      test_run_loss();
      test_clear_status();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_pll_lock_supervisor.md
Name: adc_pll_lock_supervisor

Overview:
Free-running supervisor clocked from the ADC PLL's reference clock. It drives the PLL reset, qualifies the PLL lock indication and retries on lock timeout. It releases the ADC-path reset only after lock has been stable for a programmed time. It also detects and counts loss-of-lock during operation and triggers an automatic relock.

Parameters:
RST_PULSE_CYC, 16, cycles pll_rst is held high per reset attempt (>=2)
LOCK_STABLE_CYC, 1024, consecutive synchronized-locked cycles required before release (>=1)
LOCK_TIMEOUT_CYC, 65536, cycles allowed in WAIT_LOCK before a retry (>=4)
MAX_RETRIES, 7, retries allowed after the first attempt before FAIL (1..15)
CNT_W, 17, width of the shared cycle counter; must hold the largest of the three cycle parameters

Ports:
refclk  in  1  PLL reference clock (125 MHz); the only clock
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock flag, asynchronous to refclk
force_relock  in  1  single-cycle request to restart the lock sequence
clear_status  in  1  single-cycle clear for lock_lost and lock_loss_cnt
pll_rst  out  1  active-high reset to the PLL
adc_rst_n  out  1  active-low reset for ADC capture logic; high only in RUN
ready  out  1  high only in RUN
fail  out  1  high only in FAIL
lock_lost  out  1  sticky flag: lock dropped while in RUN
lock_loss_cnt  out  8  saturating count of RUN-state lock losses
retry_cnt  out  4  retries used in the current acquisition

Behaviour:
- Clocking and reset: single clock refclk; reset is asynchronous, active-low (rst_n).
- pll_locked passes through a 2-flop synchronizer (locked_s). Both flops reset to 0.
- All outputs are registered and change on the same edge as the state transition.
- Reset values:
  - state=PLL_RST, counter=0
  - pll_rst=1, adc_rst_n=0, ready=0, fail=0
  - lock_lost=0, lock_loss_cnt=0, retry_cnt=0
- PLL_RST:
  - pll_rst=1; counter increments each cycle.
  - At counter==RST_PULSE_CYC-1: go to WAIT_LOCK, counter=0. pll_rst is high for exactly RST_PULSE_CYC cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1: go to STABILIZE, counter=0.
  - Otherwise the counter increments. At counter==LOCK_TIMEOUT_CYC-1:
    - if retry_cnt==MAX_RETRIES, go to FAIL;
    - else retry_cnt+1 and go to PLL_RST, counter=0.
- STABILIZE:
  - Counter increments while locked_s=1.
  - At counter==LOCK_STABLE_CYC-1 with locked_s=1: go to RUN.
  - If locked_s=0 at any point: go to WAIT_LOCK, counter=0. The timeout restarts and retry_cnt is unchanged.
- RUN:
  - adc_rst_n=1, ready=1; retry_cnt is cleared on entry.
  - If locked_s=0: lock_lost<=1, lock_loss_cnt increments (saturating at 255), go to PLL_RST, counter=0. adc_rst_n falls on that same edge.
- FAIL:
  - fail=1, pll_rst=1, adc_rst_n=0.
  - Only force_relock or reset exits: go to PLL_RST with retry_cnt=0.
- force_relock:
  - In any state: go to PLL_RST, counter=0, retry_cnt=0.
  - Not counted as a loss or a retry.
  - Has priority over every other transition in the same cycle.
- clear_status clears lock_lost and lock_loss_cnt. If a loss event occurs in the same cycle, the set/increment wins: lock_lost=1, count=1.
- Latency from a clean pll_locked rise in WAIT_LOCK to ready=1: 2 (sync) + 1 (to STABILIZE) + LOCK_STABLE_CYC cycles.
- Glitches on pll_locked shorter than one refclk period may be missed; this is acceptable.

Test Plan:
Parameters for all scenarios: RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRIES=2.
1. Reset, then raise pll_locked 10 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles; ready and adc_rst_n rise 11 cycles after pll_locked rises; retry_cnt=0.
2. Hold pll_locked=0 -> three pll_rst pulses of 4 cycles each, separated by 32-cycle waits; retry_cnt steps 1 then 2; fail=1 after the third timeout; pll_rst stays 1; no further pulses.
3. In FAIL, pulse force_relock with pll_locked=1 -> fail=0 next edge, 4-cycle pll_rst pulse, retry_cnt=0, then ready=1 after stabilization.
4. In STABILIZE, drop pll_locked for 3 cycles at stable count 5 -> return to WAIT_LOCK; ready only after 8 fresh consecutive locked cycles; lock_loss_cnt stays 0.
5. In RUN, drop pll_locked -> adc_rst_n=0 and ready=0 three edges later (2 sync + 1); lock_lost=1; lock_loss_cnt=1; new pll_rst pulse. Repeat 300 times -> count saturates at 255.
6. Assert clear_status on the same cycle as a RUN lock loss with lock_loss_cnt=5 -> lock_lost=1, lock_loss_cnt=1. Assert rst_n low mid-STABILIZE -> all outputs at reset values immediately, asynchronously.
